wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter -- write-back arbiter for NUM_CH result producers.
// Each channel feeds a small FIFO of {res, res_rd}. One non-empty channel
// per cycle is granted (fixed priority or round-robin), its head is popped
// and registered onto result/rd with result_v high the following cycle.
// Results targeting x0 are accepted but dropped before buffering.
//
// Ports:
//   clk, rst    single clock, synchronous active-high reset
//   res_v       per-channel result valid
//   res         per-channel data, channel i at [i*XLEN +: XLEN]
//   res_rd      per-channel destination, channel i at [i*5 +: 5]
//   ok          per-channel ready (buffer not full, low during reset)
//   result/rd   registered write-back data / destination (held when idle)
//   result_v    write-back valid (consumer always accepts)
//   occupancy   per-channel fill count, ($clog2(DEPTH)+1) bits per channel

// Per-channel buffer: DEPTH entries, wrap-around pointers, explicit count.
module wb_arbiter_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2,
  localparam int OW   = $clog2(DEPTH) + 1,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [OW-1:0] occ,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (occ == '0);
  assign full  = (occ == OW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
      // simultaneous push and pop leaves the count alone
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

module wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 2,
  parameter int MODE   = 0,
  localparam int OW    = $clog2(DEPTH) + 1,
  localparam int GW    = $clog2(NUM_CH),
  localparam int EW    = XLEN + 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    res_v,
  input  logic [NUM_CH*XLEN-1:0] res,
  input  logic [NUM_CH*5-1:0]  res_rd,
  output logic [NUM_CH-1:0]    ok,
  output logic [XLEN-1:0]      result,
  output logic [4:0]           rd,
  output logic                 result_v,
  output logic [NUM_CH*OW-1:0] occupancy
);
  logic [NUM_CH-1:0]         empty, full, push, pop;
  logic [NUM_CH-1:0][EW-1:0] head;
  logic [GW-1:0]             last_grant, gnt_idx;
  logic                      gnt_any;
  int                        cand;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // ready comes from registered fill state only, never from this cycle's pop
    assign ok[i]   = ~rst & ~full[i];
    // x0 writes are handshaken but never buffered
    assign push[i] = res_v[i] & ok[i] & (res_rd[i*5 +: 5] != 5'd0);
    assign pop[i]  = gnt_any & (gnt_idx == GW'(i));

    wb_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({res[i*XLEN +: XLEN], res_rd[i*5 +: 5]}),
      .dout  (head[i]),
      .occ   (occupancy[i*OW +: OW]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // Grant search: fixed order from ch0, or rotating start after last_grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (MODE == 1) cand = (int'(last_grant) + 1 + k) % NUM_CH;
      else           cand = k;
      if (!gnt_any && !empty[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = GW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result     <= '0;
      rd         <= '0;
      result_v   <= 1'b0;
      last_grant <= GW'(NUM_CH - 1);
    end else begin
      result_v <= gnt_any;
      if (gnt_any) begin
        {result, rd} <= head[gnt_idx];
        last_grant   <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a directed vector table on a 2-channel fixed-priority
// instance, hand sequences for reset and round-robin order, then randomized
// traffic on both instances against a queue-based reference model.
module tb_wb_arbiter;
  logic clk, rst0, rst1;

  // dut0: NUM_CH=2, DEPTH=2, MODE=0
  logic [1:0]       in0_v;
  logic [1:0][31:0] in0_d;
  logic [1:0][4:0]  in0_a;
  logic [1:0]       out0_ok;
  logic [31:0]      out0_res;
  logic [4:0]       out0_rd;
  logic             out0_rv;
  logic [1:0][1:0]  out0_occ;

  // dut1: NUM_CH=3, DEPTH=2, MODE=1
  logic [2:0]       in1_v;
  logic [2:0][31:0] in1_d;
  logic [2:0][4:0]  in1_a;
  logic [2:0]       out1_ok;
  logic [31:0]      out1_res;
  logic [4:0]       out1_rd;
  logic             out1_rv;
  logic [2:0][1:0]  out1_occ;

  wb_arbiter #(.XLEN(32), .NUM_CH(2), .DEPTH(2), .MODE(0)) dut0 (
    .clk(clk), .rst(rst0), .res_v(in0_v), .res(in0_d), .res_rd(in0_a),
    .ok(out0_ok), .result(out0_res), .rd(out0_rd), .result_v(out0_rv),
    .occupancy(out0_occ));

  wb_arbiter #(.XLEN(32), .NUM_CH(3), .DEPTH(2), .MODE(1)) dut1 (
    .clk(clk), .rst(rst1), .res_v(in1_v), .res(in1_d), .res_rd(in1_a),
    .ok(out1_ok), .result(out1_res), .rd(out1_rd), .result_v(out1_rv),
    .occupancy(out1_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [31:0] d0;
    logic [4:0]  r0;
    logic [31:0] d1;
    logic [4:0]  r1;
    logic [1:0]  ok;
    logic [1:0]  o0, o1;
    logic        rv;
    logic [31:0] res;
    logic [4:0]  rd;
  } vec_t;

  function automatic vec_t row(logic r, logic [1:0] v, logic [31:0] d0, logic [4:0] r0,
                               logic [31:0] d1, logic [4:0] r1, logic [1:0] ok,
                               logic [1:0] o0, logic [1:0] o1, logic rv,
                               logic [31:0] res, logic [4:0] rd);
    vec_t t;
    t.rst = r; t.v = v; t.d0 = d0; t.r0 = r0; t.d1 = d1; t.r1 = r1;
    t.ok = ok; t.o0 = o0; t.o1 = o1; t.rv = rv; t.res = res; t.rd = rd;
    return t;
  endfunction

  // Reference model: one queue per channel (flat index m*3+c), arbitration
  // rules applied directly to queue state.
  typedef logic [36:0] ent_t;
  ent_t        mq[6][$];
  int          last[2];
  logic        emv[2];
  logic [31:0] eres[2];
  logic [4:0]  erd[2];

  task automatic model_step(int m, int nch, int mode, logic r, logic [2:0] v,
                            logic [2:0][31:0] d, logic [2:0][4:0] a);
    bit   okv[3];
    int   g, c;
    ent_t e;
    if (r) begin
      for (int i = 0; i < 3; i++) mq[m*3+i].delete();
      emv[m] = 1'b0; eres[m] = '0; erd[m] = '0; last[m] = nch - 1;
    end else begin
      for (int i = 0; i < nch; i++) okv[i] = (mq[m*3+i].size() != 2);
      g = -1;
      for (int k = 0; k < nch; k++) begin
        c = (mode == 1) ? (last[m] + 1 + k) % nch : k;
        if (g < 0 && mq[m*3+c].size() > 0) g = c;
      end
      if (g >= 0) begin
        e = mq[m*3+g].pop_front();
        emv[m] = 1'b1; {eres[m], erd[m]} = e; last[m] = g;
      end else emv[m] = 1'b0;
      for (int i = 0; i < nch; i++)
        if (v[i] && okv[i] && a[i] != 5'd0) mq[m*3+i].push_back({d[i], a[i]});
    end
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 5) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  vec_t tbl[25];
  logic [31:0] got[$];

  initial begin
    logic [2:0]      eok;
    logic [2:0][1:0] eocc;

    tbl[0]  = row(1, 2'b00, 0, 0, 0, 0,                       2'b00, 0, 0, 0, 0, 0);
    tbl[1]  = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 0, 0, 0);
    tbl[2]  = row(0, 2'b01, 32'hDEADBEEF, 5, 0, 0,            2'b11, 0, 0, 0, 0, 0);
    tbl[3]  = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 1, 0, 0, 0, 0);
    tbl[4]  = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 1, 32'hDEADBEEF, 5);
    tbl[5]  = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 0, 32'hDEADBEEF, 5);
    tbl[6]  = row(0, 2'b10, 0, 0, 32'h1234, 0,                2'b11, 0, 0, 0, 32'hDEADBEEF, 5);
    tbl[7]  = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 0, 32'hDEADBEEF, 5);
    tbl[8]  = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 0, 32'hDEADBEEF, 5);
    tbl[9]  = row(0, 2'b11, 32'hA0000000, 1, 32'hB0000000, 2, 2'b11, 0, 0, 0, 32'hDEADBEEF, 5);
    tbl[10] = row(0, 2'b11, 32'hA0000001, 3, 32'hB0000001, 4, 2'b11, 1, 1, 0, 32'hDEADBEEF, 5);
    tbl[11] = row(0, 2'b00, 0, 0, 0, 0,                       2'b01, 1, 2, 1, 32'hA0000000, 1);
    tbl[12] = row(0, 2'b00, 0, 0, 0, 0,                       2'b01, 0, 2, 1, 32'hA0000001, 3);
    tbl[13] = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 1, 1, 32'hB0000000, 2);
    tbl[14] = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 1, 32'hB0000001, 4);
    tbl[15] = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 0, 32'hB0000001, 4);
    tbl[16] = row(0, 2'b11, 32'hC0000000, 6, 32'hD0000000, 7, 2'b11, 0, 0, 0, 32'hB0000001, 4);
    tbl[17] = row(0, 2'b11, 32'hC0000001, 8, 32'hD0000001, 9, 2'b11, 1, 1, 0, 32'hB0000001, 4);
    tbl[18] = row(0, 2'b11, 32'hC0000002, 10, 32'hD0000002, 11, 2'b01, 1, 2, 1, 32'hC0000000, 6);
    tbl[19] = row(0, 2'b10, 0, 0, 32'hD0000002, 11,           2'b01, 1, 2, 1, 32'hC0000001, 8);
    tbl[20] = row(0, 2'b10, 0, 0, 32'hD0000002, 11,           2'b01, 0, 2, 1, 32'hC0000002, 10);
    tbl[21] = row(0, 2'b10, 0, 0, 32'hD0000002, 11,           2'b11, 0, 1, 1, 32'hD0000000, 7);
    tbl[22] = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 1, 1, 32'hD0000001, 9);
    tbl[23] = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 1, 32'hD0000002, 11);
    tbl[24] = row(0, 2'b00, 0, 0, 0, 0,                       2'b11, 0, 0, 0, 32'hD0000002, 11);

    rst0 = 1'b1; rst1 = 1'b1;
    in0_v = '0; in0_d = '0; in0_a = '0;
    in1_v = '0; in1_d = '0; in1_a = '0;
    repeat (2) @(posedge clk);

    // directed table on dut0
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      rst0 = tbl[k].rst; in0_v = tbl[k].v;
      in0_d[0] = tbl[k].d0; in0_a[0] = tbl[k].r0;
      in0_d[1] = tbl[k].d1; in0_a[1] = tbl[k].r1;
      @(negedge clk);
      chk($sformatf("tbl%0d", k), {out0_ok, out0_occ, out0_rv, out0_res, out0_rd},
          {tbl[k].ok, tbl[k].o1, tbl[k].o0, tbl[k].rv, tbl[k].res, tbl[k].rd});
    end

    // reset with two entries buffered
    @(posedge clk); #1;
    in0_v = 2'b11; in0_d[0] = 32'hE0000000; in0_a[0] = 5'd1;
    in0_d[1] = 32'hE0000001; in0_a[1] = 5'd2;
    @(posedge clk); #1;
    in0_v = 2'b00; rst0 = 1'b1;
    @(negedge clk);
    chk("rst_during", {out0_ok, out0_occ, out0_rv}, {2'b00, 2'd1, 2'd1, 1'b0});
    @(posedge clk); #1;
    rst0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d", k), {out0_ok, out0_occ, out0_rv, out0_res, out0_rd},
          {2'b11, 4'd0, 1'b0, 32'd0, 5'd0});
    end

    // round-robin order on dut1
    @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    chk("rr_ok_after_rst", {61'd0, out1_ok}, 64'd7);
    @(posedge clk); #1;
    in1_v = 3'b111;
    for (int c = 0; c < 3; c++) begin in1_d[c] = 32'(c*16); in1_a[c] = 5'(c*2+1); end
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin in1_d[c] = 32'(c*16+1); in1_a[c] = 5'(c*2+2); end
    @(posedge clk); #1;
    in1_v = 3'b000;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out1_rv) got.push_back(out1_res);
    end
    chk("rr_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i), (i < got.size()) ? {32'd0, got[i]} : 64'hFFFF_FFFF_FFFF_FFFF,
          64'((i % 3) * 16 + i / 3));

    // randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      @(posedge clk); #1;
      rst0 = (n == 0) || ($urandom_range(0, 99) == 0);
      rst1 = (n == 0) || ($urandom_range(0, 99) == 0);
      for (int c = 0; c < 2; c++) begin
        in0_v[c] = ($urandom_range(0, 9) < 6); in0_d[c] = $urandom; in0_a[c] = rnd_rd();
      end
      for (int c = 0; c < 3; c++) begin
        in1_v[c] = ($urandom_range(0, 9) < 6); in1_d[c] = $urandom; in1_a[c] = rnd_rd();
      end
      @(negedge clk);
      if (n > 0) begin
        for (int c = 0; c < 2; c++) begin
          eok[c]  = !rst0 && (mq[c].size() != 2);
          eocc[c] = 2'(mq[c].size());
        end
        chk("rnd0_ok_occ", {out0_ok, out0_occ}, {eok[1:0], eocc[1:0]});
        chk("rnd0_out", {out0_rv, out0_res, out0_rd}, {emv[0], eres[0], erd[0]});
        for (int c = 0; c < 3; c++) begin
          eok[c]  = !rst1 && (mq[3+c].size() != 2);
          eocc[c] = 2'(mq[3+c].size());
        end
        chk("rnd1_ok_occ", {out1_ok, out1_occ}, {eok, eocc});
        chk("rnd1_out", {out1_rv, out1_res, out1_rd}, {emv[1], eres[1], erd[1]});
      end
      model_step(0, 2, 0, rst0, {1'b0, in0_v}, {32'd0, in0_d}, {5'd0, in0_a});
      model_step(1, 3, 1, rst1, in1_v, in1_d, in1_a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
